pl_wb_scoreboard: RTL and testbench
===================================

Name: pl_wb_scoreboard

Overview:
- Write-side initiator for the pipelined register file.
- Tracks a busy bit per architectural register from issue until writeback. Stalls issue on RAW and WAW hazards.
- Arbitrates two writeback sources onto the single register-file write port (RegWrite/AdInReg/DInReg):
  - a fixed-latency ALU pipe;
  - a variable-latency load-return channel, buffered in a small FIFO.

Parameters:
- WAD, 5, register address width (2**WAD registers).
- WD, 32, data width.
- LQ_DEPTH, 2, load-return FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  instruction presented at issue.
- issue_rs1  in  WAD  source 1 address.
- issue_rs2  in  WAD  source 2 address.
- issue_use_rs1  in  1  instruction reads rs1.
- issue_use_rs2  in  1  instruction reads rs2.
- issue_wr  in  1  instruction writes rd.
- issue_rd  in  WAD  destination address.
- issue_stall  out  1  combinational; issue must hold its instruction.
- alu_wb_valid  in  1  ALU result available; always accepted, no ready.
- alu_wb_rd  in  WAD  ALU result destination.
- alu_wb_data  in  WD  ALU result.
- ld_valid  in  1  load return valid.
- ld_ready  out  1  load FIFO not full.
- ld_rd  in  WAD  load destination.
- ld_data  in  WD  load data.
- RegWrite  out  1  register-file write enable (registered).
- AdInReg  out  WAD  register-file write address (registered).
- DInReg  out  WD  register-file write data (registered).
- busy_vec  out  2**WAD  scoreboard state; bit 0 is always 0.
- wb_err  out  1  sticky; writeback to a non-busy register.

Behaviour:
- Reset (async, rst_n=0):
  - busy_vec=0, FIFO emptied (count=0, pointers 0), RegWrite=0, AdInReg=0, DInReg=0, wb_err=0.
  - Reset mid-operation discards all pending writes and buffered loads.
- Hazard detection:
  - issue_stall = issue_valid & ((issue_use_rs1 & busy[rs1]) | (issue_use_rs2 & busy[rs2]) | (issue_wr & busy[rd])).
  - busy[0] is hard 0, so x0 never stalls.
- Issue acceptance:
  - An issue is accepted when issue_valid & !issue_stall.
  - If accepted with issue_wr=1 and rd!=0, busy[rd] is set at the next edge.
- Load FIFO:
  - ld_ready = (count < LQ_DEPTH). A push occurs when ld_valid & ld_ready.
  - A push and a pop in the same cycle leave count unchanged.
  - A push into an empty FIFO is not writable back in the same cycle; one cycle of minimum buffering.
  - Pointers wrap modulo LQ_DEPTH.
- Writeback selection (each cycle):
  - ALU has priority: if alu_wb_valid, the ALU is selected.
  - Otherwise, if the FIFO is non-empty, the FIFO head is selected and popped.
  - A load is never dropped: an ALU burst only delays the FIFO, and ld_ready deasserts when full.
- Write port:
  - Selection is registered at the next edge E: RegWrite=1, AdInReg=rd, DInReg=data.
  - If the selected rd==0: RegWrite=0, but a FIFO pop still occurs.
  - With no selection: RegWrite=0; AdInReg and DInReg hold.
- Busy clear:
  - busy[AdInReg] clears at edge E+1, while RegWrite=1. This is the same edge on which the register file captures the data.
  - Consequence: a dependent instruction unstalls only after the new value is readable.
  - Latency: alu_wb_valid at cycle N -> RegWrite high during cycle N+1 -> dependent issue accepted in cycle N+2.
- Set/clear on the same register in the same cycle cannot occur legally (WAW stall); if it does, set wins.
- wb_err:
  - Set when RegWrite=1, AdInReg!=0 and busy[AdInReg]=0.
  - Cleared only by reset.

Optional Feature:
- Macro: WB_FWD_EN.
- When defined, three outputs are added:
  - fwd_rs1_hit, 1: issue_use_rs1 & RegWrite & AdInReg==issue_rs1 & rs1!=0;
  - fwd_rs2_hit, 1: same for rs2;
  - fwd_data, WD: equals DInReg.
- With the macro defined, a RAW hazard whose register is covered by a hit does not contribute to issue_stall. Dependent issue is then accepted in cycle N+1.
- WAW stall is unchanged.
- When not defined, the ports are absent and stalling is as described under Behaviour.

Test Plan:
- Reset, then issue rd=5, issue_wr=1 -> busy_vec[5]=1 next cycle; issue with rs1=5 -> issue_stall=1.
- ALU writeback rd=5, data 0xDEADBEEF at cycle N -> RegWrite=1, AdInReg=5, DInReg=0xDEADBEEF in N+1; busy[5]=0 and stall released in N+2 (N+1 with WB_FWD_EN, fwd_data=0xDEADBEEF).
- Make busy rd=10 and rd=11. Hold alu_wb_valid=1 for 4 cycles while ld_valid returns rd=10 then rd=11 -> ld_ready=0 after 2 pushes; both loads are written after the ALU burst, in order 10 then 11.
- Issue with rd=0 plus writeback rd=0 -> busy_vec stays 0, RegWrite stays 0, wb_err=0.
- ALU writeback to non-busy rd=7 -> register written, wb_err=1 and stays 1 until reset.
- Two loads in the FIFO and busy bits set, then assert rst_n=0 mid-cycle -> immediately busy_vec=0, RegWrite=0, ld_ready=1; no buffered load is written afterward.

Source files
------------

// File: rtl/pl_wb_scoreboard_if.sv
// Bundles the issue, writeback and register-file write-port signals of pl_wb_scoreboard.
// The forwarding outputs exist only when WB_FWD_EN is defined.
interface pl_wb_scoreboard_if #(
  parameter int WAD = 5,
  parameter int WD  = 32
);
  logic                issue_valid;
  logic [WAD-1:0]      issue_rs1;
  logic [WAD-1:0]      issue_rs2;
  logic                issue_use_rs1;
  logic                issue_use_rs2;
  logic                issue_wr;
  logic [WAD-1:0]      issue_rd;
  logic                issue_stall;

  logic                alu_wb_valid;
  logic [WAD-1:0]      alu_wb_rd;
  logic [WD-1:0]       alu_wb_data;

  logic                ld_valid;
  logic                ld_ready;
  logic [WAD-1:0]      ld_rd;
  logic [WD-1:0]       ld_data;

  logic                RegWrite;
  logic [WAD-1:0]      AdInReg;
  logic [WD-1:0]       DInReg;
  logic [2**WAD-1:0]   busy_vec;
  logic                wb_err;
`ifdef WB_FWD_EN
  logic                fwd_rs1_hit;
  logic                fwd_rs2_hit;
  logic [WD-1:0]       fwd_data;
`endif

  // The scoreboard initiates register-file writes, so it takes the master side.
  modport master (
    input  issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
    input  issue_wr, issue_rd,
    input  alu_wb_valid, alu_wb_rd, alu_wb_data,
    input  ld_valid, ld_rd, ld_data,
    output issue_stall, ld_ready, RegWrite, AdInReg, DInReg, busy_vec, wb_err
`ifdef WB_FWD_EN
    , output fwd_rs1_hit, fwd_rs2_hit, fwd_data
`endif
  );

  modport slave (
    output issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
    output issue_wr, issue_rd,
    output alu_wb_valid, alu_wb_rd, alu_wb_data,
    output ld_valid, ld_rd, ld_data,
    input  issue_stall, ld_ready, RegWrite, AdInReg, DInReg, busy_vec, wb_err
`ifdef WB_FWD_EN
    , input fwd_rs1_hit, fwd_rs2_hit, fwd_data
`endif
  );
endinterface

// File: rtl/pl_wb_scoreboard.sv
// Register busy-bit scoreboard with ALU/load writeback arbitration onto one write port.
// Define WB_FWD_EN to add write-port forwarding that removes RAW stalls one cycle early.
module pl_wb_scoreboard #(
  parameter int WAD      = 5,
  parameter int WD       = 32,
  parameter int LQ_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  pl_wb_scoreboard_if.master bus
);
  localparam int NREG = 2**WAD;
  localparam int PW   = $clog2(LQ_DEPTH);
  localparam logic [PW:0] LQ_FULL = LQ_DEPTH[PW:0];

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busyNext;
  logic [WAD-1:0]  r_ldRd   [LQ_DEPTH];
  logic [WD-1:0]   r_ldData [LQ_DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [PW:0]     r_count;
  logic            r_regWrite;
  logic [WAD-1:0]  r_adInReg;
  logic [WD-1:0]   r_dInReg;
  logic            r_wbErr;

  logic            w_rs1Haz;
  logic            w_rs2Haz;
  logic            w_stall;
  logic            w_issueAcc;
  logic            w_ldReady;
  logic            w_push;
  logic            w_pop;
  logic            w_selValid;
  logic [WAD-1:0]  w_selRd;
  logic [WD-1:0]   w_selData;
  logic            w_doWrite;

`ifdef WB_FWD_EN
  logic w_fwdRs1;
  logic w_fwdRs2;
  assign w_fwdRs1 = bus.issue_use_rs1 & r_regWrite & (r_adInReg == bus.issue_rs1) &
                    (bus.issue_rs1 != '0);
  assign w_fwdRs2 = bus.issue_use_rs2 & r_regWrite & (r_adInReg == bus.issue_rs2) &
                    (bus.issue_rs2 != '0);
`endif

  // A forwarded source is readable this cycle, so only uncovered RAW hazards stall.
  always_comb begin
    w_rs1Haz = bus.issue_use_rs1 & r_busy[bus.issue_rs1];
    w_rs2Haz = bus.issue_use_rs2 & r_busy[bus.issue_rs2];
`ifdef WB_FWD_EN
    if (w_fwdRs1) w_rs1Haz = 1'b0;
    if (w_fwdRs2) w_rs2Haz = 1'b0;
`endif
    w_stall = bus.issue_valid &
              (w_rs1Haz | w_rs2Haz | (bus.issue_wr & r_busy[bus.issue_rd]));
  end

  assign w_issueAcc = bus.issue_valid & ~w_stall;

  // Count is registered, so a load pushed this cycle cannot be popped until the next.
  assign w_ldReady  = (r_count < LQ_FULL);
  assign w_push     = bus.ld_valid & w_ldReady;
  assign w_pop      = ~bus.alu_wb_valid & (r_count != '0);
  assign w_selValid = bus.alu_wb_valid | w_pop;
  assign w_selRd    = bus.alu_wb_valid ? bus.alu_wb_rd   : r_ldRd[r_rptr];
  assign w_selData  = bus.alu_wb_valid ? bus.alu_wb_data : r_ldData[r_rptr];
  assign w_doWrite  = w_selValid & (w_selRd != '0);

  // Clear lands with the register-file write; a same-cycle set on that register wins.
  always_comb begin
    w_busyNext = r_busy;
    if (r_regWrite) w_busyNext[r_adInReg] = 1'b0;
    if (w_issueAcc && bus.issue_wr && (bus.issue_rd != '0)) w_busyNext[bus.issue_rd] = 1'b1;
    w_busyNext[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_regWrite <= 1'b0;
      r_adInReg  <= '0;
      r_dInReg   <= '0;
      r_wbErr    <= 1'b0;
    end else begin
      r_busy     <= w_busyNext;
      r_regWrite <= w_doWrite;
      if (w_doWrite) begin
        r_adInReg <= w_selRd;
        r_dInReg  <= w_selData;
      end
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (r_regWrite && (r_adInReg != '0) && !r_busy[r_adInReg]) r_wbErr <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ldRd[r_wptr]   <= bus.ld_rd;
      r_ldData[r_wptr] <= bus.ld_data;
    end
  end

  assign bus.issue_stall = w_stall;
  assign bus.ld_ready    = w_ldReady;
  assign bus.RegWrite    = r_regWrite;
  assign bus.AdInReg     = r_adInReg;
  assign bus.DInReg      = r_dInReg;
  assign bus.busy_vec    = r_busy;
  assign bus.wb_err      = r_wbErr;
`ifdef WB_FWD_EN
  assign bus.fwd_rs1_hit = w_fwdRs1;
  assign bus.fwd_rs2_hit = w_fwdRs2;
  assign bus.fwd_data    = r_dInReg;
`endif
endmodule

// File: tb/tb_pl_wb_scoreboard.sv
// Bench for pl_wb_scoreboard: directed hazard/reset checks plus a queue of expected writes.
// Covers the WB_FWD_EN build as well when that macro is defined.
module tb_pl_wb_scoreboard;
  localparam int WAD = 5;
  localparam int WD  = 32;

  typedef struct packed {
    logic [WAD-1:0] rd;
    logic [WD-1:0]  data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   totalCnt = 0;
  int   badCnt = 0;
  wr_t  expQ[$];

  pl_wb_scoreboard_if #(.WAD(WAD), .WD(WD)) bus();

  pl_wb_scoreboard #(.WAD(WAD), .WD(WD), .LQ_DEPTH(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    totalCnt++;
    if (got !== exp) begin
      badCnt++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    bus.issue_valid   = 1'b0;
    bus.issue_rs1     = '0;
    bus.issue_rs2     = '0;
    bus.issue_use_rs1 = 1'b0;
    bus.issue_use_rs2 = 1'b0;
    bus.issue_wr      = 1'b0;
    bus.issue_rd      = '0;
    bus.alu_wb_valid  = 1'b0;
    bus.alu_wb_rd     = '0;
    bus.alu_wb_data   = '0;
    bus.ld_valid      = 1'b0;
    bus.ld_rd         = '0;
    bus.ld_data       = '0;
  endtask

  task automatic setIssue(input bit v, input logic [4:0] rs1, input bit u1,
                          input logic [4:0] rs2, input bit u2, input bit wr, input logic [4:0] rd);
    bus.issue_valid   = v;
    bus.issue_rs1     = rs1;
    bus.issue_use_rs1 = u1;
    bus.issue_rs2     = rs2;
    bus.issue_use_rs2 = u2;
    bus.issue_wr      = wr;
    bus.issue_rd      = rd;
  endtask

  // Drives both writeback sources for one cycle; ALU writes to x1..x31 are expected next cycle.
  task automatic applyStimulus(input bit aluV, input logic [4:0] aluRd, input logic [31:0] aluD,
                               input bit ldV, input logic [4:0] ldRd, input logic [31:0] ldD);
    bus.alu_wb_valid = aluV;
    bus.alu_wb_rd    = aluRd;
    bus.alu_wb_data  = aluD;
    bus.ld_valid     = ldV;
    bus.ld_rd        = ldRd;
    bus.ld_data      = ldD;
    if (aluV && aluRd != 5'd0) expQ.push_back('{rd: aluRd, data: aluD});
  endtask

  task automatic issueWrite(input logic [4:0] rd);
    setIssue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, rd);
    step();
    setIssue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 20) begin
      step();
      n++;
    end
    checkOutput(tag, expQ.size(), 0);
  endtask

  // Every register-file write must match the head of the expected-write queue.
  always @(negedge clk) begin
    if (rst_n && bus.RegWrite) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpWr", bus.RegWrite, 1'b0);
      end else begin
        wr_t e;
        e = expQ.pop_front();
        checkOutput("wbAddr", bus.AdInReg, e.rd);
        checkOutput("wbData", bus.DInReg, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got=running exp=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] bv;
    clearInputs();
    #2;
    checkOutput("rstBusy", bus.busy_vec, 0);
    checkOutput("rstRegWrite", bus.RegWrite, 0);
    checkOutput("rstAdIn", bus.AdInReg, 0);
    checkOutput("rstDIn", bus.DInReg, 0);
    checkOutput("rstErr", bus.wb_err, 0);
    checkOutput("rstLdReady", bus.ld_ready, 1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // RAW/WAW hazard on x5
    setIssue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5);
    #1 checkOutput("issueNoStall", bus.issue_stall, 0);
    step();
    setIssue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    checkOutput("busy5", bus.busy_vec, 32'h0000_0020);
    setIssue(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
    #1 checkOutput("rawRs1", bus.issue_stall, 1);
    setIssue(1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0);
    #1 checkOutput("rawRs2", bus.issue_stall, 1);
    setIssue(1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 1'b1, 5'd5);
    #1 checkOutput("waw", bus.issue_stall, 1);
    setIssue(1'b1, 5'd5, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0);
    #1 checkOutput("unusedSrc", bus.issue_stall, 0);

    // ALU writeback of x5 and release of the dependent issue
    setIssue(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    step();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("wrEn5", bus.RegWrite, 1);
    checkOutput("wrAd5", bus.AdInReg, 5);
`ifdef WB_FWD_EN
    checkOutput("fwdStall", bus.issue_stall, 0);
    checkOutput("fwdHit1", bus.fwd_rs1_hit, 1);
    checkOutput("fwdData", bus.fwd_data, 32'hDEADBEEF);
`else
    checkOutput("stallN1", bus.issue_stall, 1);
`endif
    step();
    checkOutput("busyClr5", bus.busy_vec, 0);
    checkOutput("stallN2", bus.issue_stall, 0);
    checkOutput("holdAd", bus.AdInReg, 5);
    setIssue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);

    // Single load into an empty FIFO: one cycle of buffering before the write
    issueWrite(5'd9);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_0909);
    expQ.push_back('{rd: 5'd9, data: 32'h0000_0909});
    step();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("ldBuffered", bus.RegWrite, 0);
    step();
    checkOutput("ldWritten", bus.RegWrite, 1);
    drain("drainLd1");

    // ALU burst delays two buffered loads; FIFO fills and ld_ready drops
    issueWrite(5'd10);
    issueWrite(5'd11);
    for (int r = 20; r < 24; r++) issueWrite(5'(r));
    bv = 32'h00F0_0C00;
    checkOutput("busyBurst", bus.busy_vec, bv);
    applyStimulus(1'b1, 5'd20, 32'h2000_0000, 1'b1, 5'd10, 32'hAAAA_0010);
    #1 checkOutput("ldReadyB0", bus.ld_ready, 1);
    step();
    applyStimulus(1'b1, 5'd21, 32'h2100_0000, 1'b1, 5'd11, 32'hBBBB_0011);
    #1 checkOutput("ldReadyB1", bus.ld_ready, 1);
    step();
    applyStimulus(1'b1, 5'd22, 32'h2200_0000, 1'b0, 5'd0, 32'd0);
    #1 checkOutput("ldFullB2", bus.ld_ready, 0);
    step();
    applyStimulus(1'b1, 5'd23, 32'h2300_0000, 1'b0, 5'd0, 32'd0);
    #1 checkOutput("ldFullB3", bus.ld_ready, 0);
    expQ.push_back('{rd: 5'd10, data: 32'hAAAA_0010});
    expQ.push_back('{rd: 5'd11, data: 32'hBBBB_0011});
    step();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("ldFullB4", bus.ld_ready, 0);
    drain("drainBurst");
    step();
    checkOutput("busyAfterBurst", bus.busy_vec, 0);
    checkOutput("errAfterBurst", bus.wb_err, 0);

    // x0 never becomes busy and is never written
    setIssue(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0);
    applyStimulus(1'b1, 5'd0, 32'h1234_5678, 1'b0, 5'd0, 32'd0);
    #1 checkOutput("x0Stall", bus.issue_stall, 0);
    step();
    setIssue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("x0Busy", bus.busy_vec, 0);
    checkOutput("x0Write", bus.RegWrite, 0);
    step();
    checkOutput("x0Err", bus.wb_err, 0);

    // Writeback to a non-busy register raises sticky wb_err
    applyStimulus(1'b1, 5'd7, 32'h0000_0077, 1'b0, 5'd0, 32'd0);
    step();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("errNotYet", bus.wb_err, 0);
    step();
    checkOutput("errSet", bus.wb_err, 1);
    for (int i = 0; i < 3; i++) step();
    checkOutput("errSticky", bus.wb_err, 1);

    // Asynchronous reset with buffered loads discards everything
    issueWrite(5'd12);
    issueWrite(5'd13);
    applyStimulus(1'b1, 5'd0, 32'd0, 1'b1, 5'd12, 32'hCCCC_0012);
    step();
    applyStimulus(1'b1, 5'd0, 32'd0, 1'b1, 5'd13, 32'hDDDD_0013);
    step();
    applyStimulus(1'b1, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("preRstFull", bus.ld_ready, 0);
    checkOutput("preRstBusy", bus.busy_vec, 32'h0000_3000);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRstBusy", bus.busy_vec, 0);
    checkOutput("midRstWrite", bus.RegWrite, 0);
    checkOutput("midRstReady", bus.ld_ready, 1);
    checkOutput("midRstErr", bus.wb_err, 0);
    clearInputs();
    expQ.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step();
    checkOutput("postRstWrite", bus.RegWrite, 0);
    checkOutput("postRstBusy", bus.busy_vec, 0);

    checkOutput("leftover", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end
endmodule
